// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and source enum for the register-file write arbiter
package rf_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int CNT_W    = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// rtl/rf_write_arbiter_if.sv - writeback request channel (valid/addr/data in, ready out)
// master: producer side (drives valid, addr, data; samples ready)
// slave:  arbiter side  (samples valid, addr, data; drives ready)
interface rf_write_arbiter_if;

    logic                      valid;
    logic [rf_pkg::ADDR_W-1:0] addr;
    logic [rf_pkg::DATA_W-1:0] data;
    logic                      ready;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter holding the last_grant flop
// Ports: clk, rst_n (async active-low); req_alu/req_mem requests in;
//        gnt_alu/gnt_mem combinational one-hot-or-zero grants out.
module rr_arb2
    import rf_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_alu,
    input  logic req_mem,
    output logic gnt_alu,
    output logic gnt_mem
);

    src_e last_grant_q;
    src_e last_grant_d;

    always_comb begin
        gnt_alu = 1'b0;
        gnt_mem = 1'b0;
        if (req_alu && req_mem) begin
            // Contention: the source that did not win last time goes now.
            if (last_grant_q == SRC_MEM) begin
                gnt_alu = 1'b1;
            end else begin
                gnt_mem = 1'b1;
            end
        end else begin
            gnt_alu = req_alu;
            gnt_mem = req_mem;
        end

        last_grant_d = last_grant_q;
        if (gnt_alu) begin
            last_grant_d = SRC_ALU;
        end else if (gnt_mem) begin
            last_grant_d = SRC_MEM;
        end
    end

    // Reset to MEM so the ALU wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= SRC_MEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - shares the register-file write port between ALU and MEM writeback
// Ports: clk, rst_n (async active-low); alu/mem request channels (slave modport);
//        issue_valid/issue_addr claim a destination; wr_en/wr_addr/wr_data registered
//        write port; busy_mask per-register pending flags; err sticky scoreboard error.
module rf_write_arbiter
    import rf_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    rf_write_arbiter_if.slave    alu,
    rf_write_arbiter_if.slave    mem,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_addr,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic [NUM_REGS-1:0]  busy_mask,
    output logic                 err
);

    logic gnt_alu;
    logic gnt_mem;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_alu (alu.valid),
        .req_mem (mem.valid),
        .gnt_alu (gnt_alu),
        .gnt_mem (gnt_mem)
    );

    assign alu.ready = gnt_alu;
    assign mem.ready = gnt_mem;

    logic                accept;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_data;

    logic                wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                err_q,     err_d;
    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;

    always_comb begin
        // Grants are ready-gated by valid, so a grant is already an accept.
        accept   = gnt_alu | gnt_mem;
        acc_addr = gnt_mem ? mem.addr : alu.addr;
        acc_data = gnt_mem ? mem.data : alu.data;

        wr_en_d   = accept;
        wr_addr_d = accept ? acc_addr : wr_addr_q;
        wr_data_d = accept ? acc_data : wr_data_q;

        err_d   = err_q;
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_vec[i] = issue_valid && (issue_addr == ADDR_W'(i));
            // Pending write retires at accept time, not when wr_en is seen.
            dec_vec[i] = accept && (acc_addr == ADDR_W'(i));
            cnt_d[i]   = cnt_q[i];
            if (inc_vec[i] && !dec_vec[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (dec_vec[i] && !inc_vec[i]) begin
                // Write without a prior issue: flag it, but the write still goes out.
                if (cnt_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_mask[i] = (cnt_q[i] != '0);
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign err     = err_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_write_arbiter_if alu_if ();
    rf_write_arbiter_if mem_if ();

    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_addr;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [NUM_REGS-1:0] busy_mask;
    logic                err;

    rf_write_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu         (alu_if),
        .mem         (mem_if),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy_mask   (busy_mask),
        .err         (err)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: counts of outstanding writes, whose turn it is, expected port.
    int          cnt_m [NUM_REGS];
    bit          err_m;
    int          last_m;     // 0 = ALU won last, 1 = MEM won last
    bit          ex_en;
    int          ex_addr;
    logic [31:0] ex_data;
    bit          ga_m, gm_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) cnt_m[i] = 0;
        err_m   = 0;
        last_m  = 1;
        ex_en   = 0;
        ex_addr = 0;
        ex_data = 32'h0;
    endtask

    task automatic drive_idle();
        alu_if.valid = 1'b0; alu_if.addr = '0; alu_if.data = '0;
        mem_if.valid = 1'b0; mem_if.addr = '0; mem_if.data = '0;
        issue_valid  = 1'b0; issue_addr  = '0;
    endtask

    function automatic logic [15:0] model_busy();
        logic [15:0] b;
        b = '0;
        for (int i = 0; i < NUM_REGS; i++) b[i] = (cnt_m[i] > 0);
        return b;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_wr_en", 32'(wr_en), 32'h0);
        check("rst_wr_addr", 32'(wr_addr), 32'h0);
        check("rst_wr_data", wr_data, 32'h0);
        check("rst_busy", 32'(busy_mask), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycle(input bit av, input int aa, input logic [31:0] ad,
                         input bit mv, input int ma, input logic [31:0] md,
                         input bit iv, input int ia);
        int gaddr;
        @(negedge clk);
        alu_if.valid = av; alu_if.addr = ADDR_W'(aa); alu_if.data = ad;
        mem_if.valid = mv; mem_if.addr = ADDR_W'(ma); mem_if.data = md;
        issue_valid  = iv; issue_addr  = ADDR_W'(ia);
        #1;
        // Whoever did not win last takes a contended cycle.
        ga_m = av && (!mv || last_m == 1);
        gm_m = mv && !ga_m;
        check("alu_ready", 32'(alu_if.ready), 32'(ga_m));
        check("mem_ready", 32'(mem_if.ready), 32'(gm_m));
        gaddr = ga_m ? aa : ma;
        ex_en = ga_m || gm_m;
        if (ex_en) begin
            last_m  = ga_m ? 0 : 1;
            ex_addr = gaddr;
            ex_data = ga_m ? ad : md;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            bit inc, dec;
            inc = iv && ia == i;
            dec = ex_en && gaddr == i;
            if (inc && !dec) begin
                if (cnt_m[i] == 3) err_m = 1; else cnt_m[i] = cnt_m[i] + 1;
            end else if (dec && !inc) begin
                if (cnt_m[i] == 0) err_m = 1; else cnt_m[i] = cnt_m[i] - 1;
            end
        end
        @(posedge clk);
        #1;
        check("wr_en", 32'(wr_en), 32'(ex_en));
        check("wr_addr", 32'(wr_addr), 32'(ex_addr));
        check("wr_data", wr_data, ex_data);
        check("busy_mask", 32'(busy_mask), 32'(model_busy()));
        check("err", 32'(err), 32'(err_m));
    endtask

    bit          pa, pm, iv_r;
    int          aa_r, ma_r, ia_r;
    logic [31:0] ad_r, md_r;
    bit          got;

    initial begin
        drive_idle();
        model_reset();
        do_reset();

        // Single ALU write after reset; no issue so err also rises.
        cycle(1, 3, 32'h2A, 0, 0, 0, 0, 0);
        check("t1_addr", 32'(wr_addr), 32'd3);
        check("t1_data", wr_data, 32'h2A);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check("t1_en_drop", 32'(wr_en), 32'h0);

        // Contention: ALU first, MEM next, then strict alternation.
        do_reset();
        cycle(1, 1, 32'h11, 1, 2, 32'h22, 0, 0);
        check("c_first", 32'(wr_addr), 32'd1);
        cycle(0, 0, 0, 1, 2, 32'h22, 0, 0);
        check("c_second", 32'(wr_addr), 32'd2);
        for (int j = 0; j < 4; j++) begin
            cycle(1, j, 32'h100 + 32'(j), 1, j + 8, 32'h200 + 32'(j), 0, 0);
            check("c_alt", 32'(wr_addr), (j % 2 == 0) ? 32'(j) : 32'(j + 8));
        end

        // Scoreboard counting, same-cycle inc/dec, saturation.
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 1, 5);
        cycle(0, 0, 0, 0, 0, 0, 1, 5);
        check("sb5_busy2", 32'(busy_mask[5]), 32'h1);
        cycle(1, 5, 32'h55, 0, 0, 0, 0, 0);
        check("sb5_busy1", 32'(busy_mask[5]), 32'h1);
        cycle(0, 0, 0, 1, 5, 32'h56, 0, 0);
        check("sb5_busy0", 32'(busy_mask[5]), 32'h0);
        check("sb5_err", 32'(err), 32'h0);
        cycle(0, 0, 0, 0, 0, 0, 1, 7);
        cycle(1, 7, 32'h77, 0, 0, 0, 1, 7);
        check("sb7_busy", 32'(busy_mask[7]), 32'h1);
        for (int j = 0; j < 3; j++) cycle(0, 0, 0, 0, 0, 0, 1, 9);
        check("sb9_noerr", 32'(err), 32'h0);
        cycle(0, 0, 0, 0, 0, 0, 1, 9);
        check("sb9_sat_err", 32'(err), 32'h1);
        for (int j = 0; j < 2; j++) cycle(1, 9, 32'h90 + 32'(j), 0, 0, 0, 0, 0);
        check("sb9_still_busy", 32'(busy_mask[9]), 32'h1);
        cycle(1, 9, 32'h92, 0, 0, 0, 0, 0);
        check("sb9_cleared", 32'(busy_mask[9]), 32'h0);

        // Write without issue still reaches the register file.
        do_reset();
        cycle(0, 0, 0, 1, 4, 32'hBEEF, 0, 0);
        check("r4_data", wr_data, 32'hBEEF);
        check("r4_err", 32'(err), 32'h1);
        check("r4_busy", 32'(busy_mask[4]), 32'h0);

        // MEM request held stable while ALU keeps requesting.
        do_reset();
        got = 0;
        for (int k = 0; k < 5 && !got; k++) begin
            cycle(1, k, 32'hA0 + 32'(k), 1, 6, 32'h5A5A, 0, 0);
            got = gm_m;
        end
        check("stall_granted", 32'(got), 32'h1);
        check("stall_data", wr_data, 32'h5A5A);

        // Randomized traffic; requests held until accepted, reset halfway.
        pa = 0; pm = 0;
        aa_r = 0; ma_r = 0; ad_r = 0; md_r = 0;
        for (int k = 0; k < 400; k++) begin
            if (k == 200) begin
                do_reset();
                pa = 0; pm = 0;
            end
            if (!pa && $urandom_range(0, 9) < 5) begin
                pa = 1; aa_r = int'($urandom_range(0, 15)); ad_r = $urandom;
            end
            if (!pm && $urandom_range(0, 9) < 5) begin
                pm = 1; ma_r = int'($urandom_range(0, 15)); md_r = $urandom;
            end
            iv_r = ($urandom_range(0, 9) < 4);
            ia_r = int'($urandom_range(0, 15));
            cycle(pa, aa_r, ad_r, pm, ma_r, md_r, iv_r, ia_r);
            if (ga_m) pa = 0;
            if (gm_m) pm = 0;
        end

        // Asynchronous reset in the middle of a write.
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 1, 6);
        cycle(1, 2, 32'hABCD, 1, 3, 32'h3333, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(wr_en), 32'h0);
        check("mid_rst_busy", 32'(busy_mask), 32'h0);
        check("mid_rst_err", 32'(err), 32'h0);
        model_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        cycle(1, 8, 32'h88, 1, 3, 32'h3333, 0, 0);
        check("post_rst_alu_first", 32'(wr_addr), 32'd8);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
